wave_sampler: RTL and testbench
===============================

WAVE_SAMPLER -- requirements
Module: wave_sampler

Interface
REQ-001 SHALL have parameter: DW, 12, output sample width (unsigned, offset-binary).
REQ-002 SHALL have parameter: AW, 10, table address width.
REQ-003 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: addr  input  AW  phase address from the address generator.
REQ-006 SHALL have port: sig_type  input  4  waveform select: 0 sine, 1 square, 2 sawtooth, 3 triangle, others midscale.
REQ-007 SHALL have port: amplitude  input  9  gain, 256 = unity; values >256 clamped to 256.
REQ-008 SHALL have port: mem_en  output  1  sine-table read strobe.
REQ-009 SHALL have port: mem_addr  output  AW  sine-table address.
REQ-010 SHALL have port: mem_rdata  input  DW  sine-table data, valid exactly 1 cycle after mem_en.
REQ-011 SHALL have port: s_data  output  DW  scaled sample.
REQ-012 SHALL have port: s_valid  output  1  sample valid.
REQ-013 SHALL have port: s_ready  input  1  downstream (DAC) ready.

Function
REQ-014 SHALL register addr each cycle into addr_q; an update is addr != addr_q, or the one-shot start flag set by reset.
REQ-015 SHALL latch each update's addr and sig_type into a pending slot with pending flag; a later update overwrites the slot.
REQ-016 SHALL run FSM IDLE -> FETCH -> WAIT -> SCALE -> EMIT -> IDLE/FETCH.
REQ-017 IDLE: go to FETCH when pending=1; consume slot, clear pending (unless a new update arrives the same cycle).
REQ-018 FETCH: mem_en=1, mem_addr=slot addr for exactly 1 cycle, only when type=0; other types skip the memory read but still traverse WAIT.
REQ-019 WAIT: raw = mem_rdata (sine); square = addr MSB ? 2^DW-1 : 0; sawtooth = addr zero-extended and left-aligned to DW bits (addr<<(DW-AW)); triangle = MSB ? ~(addr[AW-2:0]) : addr[AW-2:0], left-aligned to DW; others = 2^(DW-1).
REQ-020 SCALE: s = 2^(DW-1) + (((raw - 2^(DW-1)) * amp_clamped) >>> 8), signed arithmetic, result in [0, 2^DW-1], no overflow.
REQ-021 EMIT: s_valid=1, s_data stable until s_valid && s_ready; then FETCH if pending else IDLE.
REQ-022 Latency: update at edge N -> s_valid asserted at edge N+5 when s_ready held high.
REQ-023 Update during EMIT handshake cycle SHALL be captured and processed next (no loss).
REQ-024 s_data/s_valid SHALL never change while s_valid=1 && s_ready=0.
REQ-025 amplitude SHALL be sampled in SCALE; amplitude=0 yields 2^(DW-1).

Reset
REQ-026 rst_n low SHALL immediately clear: state=IDLE, s_valid=0, s_data=2^(DW-1), mem_en=0, mem_addr=0, pending=0, addr_q=0.
REQ-027 Reset release SHALL set start flag so one sample for the current addr is produced without an addr change.
REQ-028 Reset mid-operation SHALL abandon the in-flight sample; no partial output.

Configuration
REQ-029 With WAVE_SAMPLER_DROP_CNT_EN defined: output drop_cnt (16 bits, reset 0) SHALL increment when an update overwrites a set pending slot, saturating at 0xFFFF.
REQ-030 Without WAVE_SAMPLER_DROP_CNT_EN: port and counter absent; overwrite behaviour unchanged.

Verification
REQ-031 Reset release, addr=0, type=1, amp=256, s_ready=1 -> one sample s_data=0x000 at cycle 5, then s_valid stays 0.
REQ-032 type=0, addr 0x000->0x100, mem model returns 0xFFF -> mem_en one cycle with mem_addr=0x100; s_data=0xFFF (amp 256), 0xBFF (amp 128).
REQ-033 type=2, addr=0x200, amp=300 -> treated as 256, s_data=0x800; amp=0 -> 0x800.
REQ-034 s_ready=0 for 20 cycles while addr steps 3 times -> s_data frozen; after ready only latest addr output; drop_cnt=2 (macro on).
REQ-035 addr change on the same cycle as EMIT handshake -> next sample emitted 4 cycles later, none lost.
REQ-036 rst_n pulsed low during WAIT -> outputs at reset values same cycle; after release one fresh sample for current addr.

Source files
------------

// File: rtl/wave_sampler.sv
// rtl/wave_sampler.sv - table/synthetic waveform sampler with gain scaling and valid/ready output
// Optional drop counter output enabled by defining WAVE_SAMPLER_DROP_CNT_EN.
module wave_sampler #(
   parameter int DW = 12,
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] addr,
   input  logic [3:0]    sig_type,
   input  logic [8:0]    amplitude,
   output logic          mem_en,
   output logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_rdata,
   output logic [DW-1:0] s_data,
   output logic          s_valid,
   input  logic          s_ready
`ifdef WAVE_SAMPLER_DROP_CNT_EN
   ,
   output logic [15:0]   drop_cnt
`endif
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_SCALE = 3'd3;
   localparam logic [2:0] S_EMIT  = 3'd4;

   localparam logic [DW-1:0] MID = DW'(1) << (DW-1);

   logic [2:0]          state, state_nxt;
   logic [AW-1:0]       addr_q;
   logic                start;
   logic                pending;
   logic [AW-1:0]       slot_addr, cur_addr;
   logic [3:0]          slot_type, cur_type;
   logic [DW-1:0]       raw_q, raw_nxt, scaled;
   logic [AW-2:0]       tri_bits;
   logic [8:0]          amp_c;
   logic signed [DW:0]  diff;
   logic signed [DW+10:0] prod;
   logic                update, hs, consume;

   assign update  = (addr != addr_q) || start;
   assign hs      = s_valid && s_ready;
   // The slot is consumed whenever the FSM is about to enter FETCH.
   assign consume = pending && ((state == S_IDLE) || ((state == S_EMIT) && hs));

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (pending) state_nxt = S_FETCH;
         S_FETCH: state_nxt = S_WAIT;
         S_WAIT:  state_nxt = S_SCALE;
         S_SCALE: state_nxt = S_EMIT;
         S_EMIT:  if (hs) state_nxt = pending ? S_FETCH : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign tri_bits = cur_addr[AW-1] ? ~cur_addr[AW-2:0] : cur_addr[AW-2:0];

   always_comb begin
      raw_nxt = MID;
      case (cur_type)
         4'd0:    raw_nxt = mem_rdata;
         4'd1:    raw_nxt = {DW{cur_addr[AW-1]}};
         4'd2:    raw_nxt = DW'(cur_addr) << (DW-AW);
         4'd3:    raw_nxt = DW'(tri_bits) << (DW-AW+1);
         default: raw_nxt = MID;
      endcase
   end

   // Gain of at most unity keeps the signed result inside the DW-bit range.
   assign amp_c  = (amplitude > 9'd256) ? 9'd256 : amplitude;
   assign diff   = $signed({1'b0, raw_q}) - $signed({1'b0, MID});
   assign prod   = (DW+11)'(diff) * (DW+11)'($signed({1'b0, amp_c}));
   assign scaled = DW'((prod >>> 8) + $signed((DW+11)'(MID)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         addr_q    <= '0;
         start     <= 1'b1;
         pending   <= 1'b0;
         slot_addr <= '0;
         slot_type <= '0;
         cur_addr  <= '0;
         cur_type  <= '0;
         raw_q     <= MID;
         mem_en    <= 1'b0;
         mem_addr  <= '0;
         s_data    <= MID;
         s_valid   <= 1'b0;
      end else begin
         state  <= state_nxt;
         addr_q <= addr;
         start  <= 1'b0;
         if (update) begin
            slot_addr <= addr;
            slot_type <= sig_type;
            pending   <= 1'b1;
         end else if (consume) begin
            pending <= 1'b0;
         end
         if (consume) begin
            cur_addr <= slot_addr;
            cur_type <= slot_type;
         end
         mem_en <= consume && (slot_type == 4'd0);
         if (consume && (slot_type == 4'd0)) mem_addr <= slot_addr;
         if (state == S_WAIT) raw_q <= raw_nxt;
         if (state == S_SCALE) begin
            s_data  <= scaled;
            s_valid <= 1'b1;
         end else if (hs) begin
            s_valid <= 1'b0;
         end
      end
   end

`ifdef WAVE_SAMPLER_DROP_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= 16'd0;
      end else if (update && pending && !consume && (drop_cnt != 16'hFFFF)) begin
         drop_cnt <= drop_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_wave_sampler.sv
// tb/tb_wave_sampler.sv - scoreboard bench for wave_sampler
module tb_wave_sampler;
   localparam int DW = 12;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [3:0]    sig_type = 4'd1;
   logic [8:0]    amplitude = 9'd256;
   logic          mem_en;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_rdata = '0;
   logic [DW-1:0] s_data;
   logic          s_valid;
   logic          s_ready = 1'b1;
   logic [DW-1:0] mem_val = '0;
`ifdef WAVE_SAMPLER_DROP_CNT_EN
   logic [15:0]   drop_cnt;
   int            drop_base;
`endif

   always #5 clk = ~clk;

   wave_sampler #(.DW(DW), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .addr(addr), .sig_type(sig_type),
      .amplitude(amplitude), .mem_en(mem_en), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .s_data(s_data), .s_valid(s_valid),
      .s_ready(s_ready)
`ifdef WAVE_SAMPLER_DROP_CNT_EN
      , .drop_cnt(drop_cnt)
`endif
   );

   always @(posedge clk) mem_rdata <= mem_en ? mem_val : 12'hA5A;

   int            n_checks = 0;
   int            n_fail = 0;
   int            n_emit = 0;
   int            mem_pulses = 0;
   logic [AW-1:0] last_mem_addr = '0;
   logic [DW-1:0] exp_q[$];
   logic          prev_hold = 1'b0;
   logic [DW-1:0] prev_data = '0;

   typedef struct {
      logic [AW-1:0] a;
      logic [3:0]    t;
      logic [8:0]    amp;
      logic [DW-1:0] m;
      logic [DW-1:0] e;
   } vec_t;
   vec_t vecs[12];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && prev_hold) begin
         check("hold_valid", int'(s_valid), 1);
         check("hold_data", int'(s_data), int'(prev_data));
      end
      prev_hold = rst_n && s_valid && !s_ready;
      prev_data = s_data;
      if (mem_en) begin
         mem_pulses++;
         last_mem_addr = mem_addr;
      end
      if (rst_n && s_valid && s_ready) begin
         n_emit++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_sample: got 0x%0h expected none", s_data);
         end else begin
            check("sample", int'(s_data), int'(exp_q.pop_front()));
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic measure(input int exp_lat, input string name);
      int lat = 0;
      do begin
         step(1);
         lat++;
      end while (!s_valid && lat < 30);
      check(name, lat, exp_lat);
   endtask

   task automatic wait_drain();
      int k = 0;
      while (exp_q.size() != 0 && k < 100) begin
         step(1);
         k++;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int emit0;
      vecs[0]  = '{10'h100, 4'd0, 9'd256, 12'hFFF, 12'hFFF};
      vecs[1]  = '{10'h101, 4'd0, 9'd128, 12'hFFF, 12'hBFF};
      vecs[2]  = '{10'h200, 4'd2, 9'd300, 12'h000, 12'h800};
      vecs[3]  = '{10'h3FF, 4'd2, 9'd300, 12'h000, 12'hFFC};
      vecs[4]  = '{10'h201, 4'd2, 9'd0,   12'h000, 12'h800};
      vecs[5]  = '{10'h3FF, 4'd3, 9'd128, 12'h000, 12'h400};
      vecs[6]  = '{10'h0FF, 4'd3, 9'd64,  12'h000, 12'h7FE};
      vecs[7]  = '{10'h001, 4'd3, 9'd1,   12'h000, 12'h7F8};
      vecs[8]  = '{10'h1FF, 4'd1, 9'd255, 12'h000, 12'h008};
      vecs[9]  = '{10'h200, 4'd1, 9'd256, 12'h000, 12'hFFF};
      vecs[10] = '{10'h123, 4'd5, 9'd100, 12'h000, 12'h800};
      vecs[11] = '{10'h080, 4'd0, 9'd256, 12'h123, 12'h123};

      step(2);
      check("rst_s_valid", int'(s_valid), 0);
      check("rst_s_data", int'(s_data), 'h800);
      check("rst_mem_en", int'(mem_en), 0);
      check("rst_mem_addr", int'(mem_addr), 0);

      // Start flag: one square sample at addr 0 without any addr change.
      exp_q.push_back(12'h000);
      rst_n = 1'b1;
      measure(5, "start_latency");
      wait_drain();
      step(10);
      check("start_single_sample", n_emit, 1);

      for (int i = 0; i < 12; i++) begin
         mem_pulses = 0;
         amplitude = vecs[i].amp;
         mem_val = vecs[i].m;
         sig_type = vecs[i].t;
         addr = vecs[i].a;
         exp_q.push_back(vecs[i].e);
         measure(5, "latency");
         wait_drain();
         check("mem_pulses", mem_pulses, (vecs[i].t == 4'd0) ? 1 : 0);
         if (vecs[i].t == 4'd0) check("mem_addr", int'(last_mem_addr), int'(vecs[i].a));
      end

      // Stalled output while addr steps three times: only the latest survives.
      emit0 = n_emit;
      s_ready = 1'b0;
      sig_type = 4'd2;
      amplitude = 9'd256;
      addr = 10'h010;
      exp_q.push_back(12'h040);
      measure(5, "stall_latency");
`ifdef WAVE_SAMPLER_DROP_CNT_EN
      drop_base = int'(drop_cnt);
`endif
      step(3);
      addr = 10'h020;
      step(6);
      addr = 10'h030;
      step(6);
      addr = 10'h040;
      exp_q.push_back(12'h100);
      step(5);
      check("stall_valid", int'(s_valid), 1);
      check("stall_data", int'(s_data), 'h040);
`ifdef WAVE_SAMPLER_DROP_CNT_EN
      check("drop_cnt", int'(drop_cnt) - drop_base, 2);
`endif
      s_ready = 1'b1;
      wait_drain();
      step(8);
      check("stall_emit_count", n_emit - emit0, 2);

      // Update arriving in the handshake cycle is kept.
      emit0 = n_emit;
      addr = 10'h050;
      exp_q.push_back(12'h140);
      measure(5, "hs_first_latency");
      addr = 10'h060;
      exp_q.push_back(12'h180);
      measure(5, "hs_update_latency");
      wait_drain();
      step(8);
      check("hs_emit_count", n_emit - emit0, 2);

      // Reset while in WAIT abandons the in-flight sample.
      emit0 = n_emit;
      addr = 10'h070;
      step(3);
      rst_n = 1'b0;
      #1;
      check("midrst_s_valid", int'(s_valid), 0);
      check("midrst_s_data", int'(s_data), 'h800);
      check("midrst_mem_en", int'(mem_en), 0);
      check("midrst_mem_addr", int'(mem_addr), 0);
      step(2);
      exp_q.push_back(12'h1C0);
      rst_n = 1'b1;
      measure(5, "post_reset_latency");
      wait_drain();
      step(10);
      check("post_reset_emit_count", n_emit - emit0, 1);
      check("queue_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
